// File: rtl/reg_rename_file_pkg.sv
// Shared widths and types for the register file / rename table.
// Imported by the interface, the read port and the top.
package reg_rename_file_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_ID_W = 5;
  localparam int NUM_REGS = 32;
  localparam int ROB_SZ   = 16;
  localparam int ROB_ID_W = $clog2(ROB_SZ);

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

endpackage

// File: rtl/reg_rename_file_if.sv
// Issue, commit and source-query bundle between
// decoder/ROB (master) and the rename file (slave).
interface reg_rename_file_if;
  import reg_rename_file_pkg::*;

  logic    rdy;
  logic    rollback;
  logic    issue_valid;
  reg_id_t issue_rd;
  rob_id_t issue_rob_id;
  logic    commit_valid;
  reg_id_t commit_rd;
  data_t   commit_data;
  rob_id_t commit_rob_id;
  reg_id_t rs1_id;
  logic    rs1_busy;
  data_t   rs1_data;
  rob_id_t rs1_rob_id;
  reg_id_t rs2_id;
  logic    rs2_busy;
  data_t   rs2_data;
  rob_id_t rs2_rob_id;

  modport master (
    output rdy, rollback,
    output issue_valid, issue_rd, issue_rob_id,
    output commit_valid, commit_rd,
    output commit_data, commit_rob_id,
    output rs1_id, rs2_id,
    input  rs1_busy, rs1_data, rs1_rob_id,
    input  rs2_busy, rs2_data, rs2_rob_id
  );

  modport slave (
    input  rdy, rollback,
    input  issue_valid, issue_rd, issue_rob_id,
    input  commit_valid, commit_rd,
    input  commit_data, commit_rob_id,
    input  rs1_id, rs2_id,
    output rs1_busy, rs1_data, rs1_rob_id,
    output rs2_busy, rs2_data, rs2_rob_id
  );

endinterface

// File: rtl/reg_rename_file_read_port.sv
// One source-operand lookup: storage mux, commit
// bypass for the matching producer, x0 masking.
module reg_rename_file_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_id_t                     i_rs_id,
  input  logic    [NUM_REGS-1:0]      i_busy,
  input  data_t   [NUM_REGS-1:0]      i_regs,
  input  rob_id_t [NUM_REGS-1:0]      i_tags,
  input  logic                        i_commit_valid,
  input  reg_id_t                     i_commit_rd,
  input  data_t                       i_commit_data,
  input  rob_id_t                     i_commit_rob_id,
  output logic                        o_busy,
  output data_t                       o_data,
  output rob_id_t                     o_rob_id
);

  logic    w_zero;
  logic    w_busy;
  data_t   w_data;
  rob_id_t w_tag;
  logic    w_fwd;

  assign w_zero = (i_rs_id == '0);
  assign w_busy = i_busy[i_rs_id];
  assign w_data = i_regs[i_rs_id];
  assign w_tag  = i_tags[i_rs_id];

  // Bypass only when the retiring op is still the newest producer.
  assign w_fwd = !w_zero && w_busy &&
                 i_commit_valid &&
                 (i_commit_rd == i_rs_id) &&
                 (w_tag == i_commit_rob_id);

  // Select zero, bypassed, or stored view of the source.
  always_comb begin
    o_busy   = 1'b0;
    o_data   = '0;
    o_rob_id = '0;
    unique case (1'b1)
      w_zero: begin
        o_busy   = 1'b0;
        o_data   = '0;
        o_rob_id = '0;
      end
      w_fwd: begin
        o_busy   = 1'b0;
        o_data   = i_commit_data;
        o_rob_id = w_tag;
      end
      default: begin
        o_busy   = w_busy;
        o_data   = w_data;
        o_rob_id = w_tag;
      end
    endcase
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename table;
// receives ROB commits, decoder renames and flushes.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input logic               clk,
  input logic               rst,
  reg_rename_file_if.slave  bus
);

  data_t   [NUM_REGS-1:0] r_regs;
  logic    [NUM_REGS-1:0] r_busy;
  rob_id_t [NUM_REGS-1:0] r_tags;

  logic w_commit_we;
  logic w_commit_hit;
  logic w_issue_we;

  assign w_commit_we  = bus.commit_valid &&
                        (bus.commit_rd != '0);
  assign w_commit_hit = w_commit_we &&
    (r_tags[bus.commit_rd] == bus.commit_rob_id);
  assign w_issue_we   = bus.issue_valid &&
                        (bus.issue_rd != '0) &&
                        !bus.rollback;

  // Commit, then issue (issue wins on same rd), then flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs <= '0;
      r_busy <= '0;
      r_tags <= '0;
    end else if (bus.rdy) begin
      if (w_commit_we)
        r_regs[bus.commit_rd] <= bus.commit_data;
      if (w_commit_hit)
        r_busy[bus.commit_rd] <= 1'b0;
      if (w_issue_we) begin
        r_busy[bus.issue_rd] <= 1'b1;
        r_tags[bus.issue_rd] <= bus.issue_rob_id;
      end
      if (bus.rollback) begin
        r_busy <= '0;
        r_tags <= '0;
      end
    end
  end

  reg_rename_file_read_port u_rs1 (
    .i_rs_id         (bus.rs1_id),
    .i_busy          (r_busy),
    .i_regs          (r_regs),
    .i_tags          (r_tags),
    .i_commit_valid  (bus.commit_valid),
    .i_commit_rd     (bus.commit_rd),
    .i_commit_data   (bus.commit_data),
    .i_commit_rob_id (bus.commit_rob_id),
    .o_busy          (bus.rs1_busy),
    .o_data          (bus.rs1_data),
    .o_rob_id        (bus.rs1_rob_id)
  );

  reg_rename_file_read_port u_rs2 (
    .i_rs_id         (bus.rs2_id),
    .i_busy          (r_busy),
    .i_regs          (r_regs),
    .i_tags          (r_tags),
    .i_commit_valid  (bus.commit_valid),
    .i_commit_rd     (bus.commit_rd),
    .i_commit_data   (bus.commit_data),
    .i_commit_rob_id (bus.commit_rob_id),
    .o_busy          (bus.rs2_busy),
    .o_data          (bus.rs2_data),
    .o_rob_id        (bus.rs2_rob_id)
  );

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed and randomized checks of the rename file
// against a per-register architectural model.
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_rename_file_if bus ();

  reg_rename_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_reg  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  task automatic idle();
    bus.rdy           = 1'b1;
    bus.rollback      = 1'b0;
    bus.issue_valid   = 1'b0;
    bus.issue_rd      = '0;
    bus.issue_rob_id  = '0;
    bus.commit_valid  = 1'b0;
    bus.commit_rd     = '0;
    bus.commit_data   = '0;
    bus.commit_rob_id = '0;
  endtask

  task automatic issue(input int rd, input int tag);
    bus.issue_valid  = 1'b1;
    bus.issue_rd     = rd[4:0];
    bus.issue_rob_id = tag[3:0];
  endtask

  task automatic commit(input int rd, input int tag,
                        input logic [31:0] d);
    bus.commit_valid  = 1'b1;
    bus.commit_rd     = rd[4:0];
    bus.commit_rob_id = tag[3:0];
    bus.commit_data   = d;
  endtask

  // Clock edge; the model applies the architectural rules
  // to the inputs presented at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (bus.rdy) begin
      int cr, ir;
      cr = int'(bus.commit_rd);
      ir = int'(bus.issue_rd);
      if (bus.commit_valid && cr != 0) begin
        m_reg[cr] = bus.commit_data;
        if (m_tag[cr] == bus.commit_rob_id)
          m_busy[cr] = 0;
      end
      if (bus.issue_valid && ir != 0 && !bus.rollback) begin
        m_busy[ir] = 1;
        m_tag[ir]  = bus.issue_rob_id;
      end
      if (bus.rollback)
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 0; m_tag[i] = 0;
        end
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.rs1_id = 5'd5;
    bus.rs2_id = 5'd0;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%0b exp=0", bus.rs1_busy);
    end
    checks++;
    if (bus.rs1_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", bus.rs1_data);
    end
    checks++;
    if (bus.rs1_rob_id !== 4'h0) begin
      failures++;
      $display("FAIL reset_tag got=%0d exp=0", bus.rs1_rob_id);
    end
    checks++;
    if (bus.rs2_busy !== 1'b0 || bus.rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_x0 got=%0b/%h exp=0/0",
               bus.rs2_busy, bus.rs2_data);
    end
  endtask

  task automatic test_issue_commit();
    idle();
    issue(5, 3);
    tick();
    idle();
    bus.rs1_id = 5'd5;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs1_rob_id !== 4'd3) begin
      failures++;
      $display("FAIL issue_x5 got=%0b/%0d exp=1/3",
               bus.rs1_busy, bus.rs1_rob_id);
    end
    commit(5, 3, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_x5 got=%0b/%h exp=0/deadbeef",
               bus.rs1_busy, bus.rs1_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL commit_x5 got=%0b/%h exp=0/deadbeef",
               bus.rs1_busy, bus.rs1_data);
    end
  endtask

  task automatic test_stale_commit();
    idle();
    issue(7, 2);
    tick();
    issue(7, 4);
    tick();
    idle();
    commit(7, 2, 32'h11);
    bus.rs1_id = 5'd7;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b1 || bus.rs1_rob_id !== 4'd4) begin
      failures++;
      $display("FAIL stale_nobypass got=%0b/%0d exp=1/4",
               bus.rs1_busy, bus.rs1_rob_id);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rs1_data !== 32'h11 || bus.rs1_busy !== 1'b1 ||
        bus.rs1_rob_id !== 4'd4) begin
      failures++;
      $display("FAIL stale_x7 got=%h/%0b/%0d exp=11/1/4",
               bus.rs1_data, bus.rs1_busy, bus.rs1_rob_id);
    end
  endtask

  task automatic test_same_cycle();
    idle();
    issue(9, 1);
    tick();
    idle();
    commit(9, 1, 32'h22);
    issue(9, 6);
    bus.rs1_id = 5'd9;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'h22) begin
      failures++;
      $display("FAIL same_bypass got=%0b/%h exp=0/22",
               bus.rs1_busy, bus.rs1_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.rs1_data !== 32'h22 || bus.rs1_busy !== 1'b1 ||
        bus.rs1_rob_id !== 4'd6) begin
      failures++;
      $display("FAIL same_x9 got=%h/%0b/%0d exp=22/1/6",
               bus.rs1_data, bus.rs1_busy, bus.rs1_rob_id);
    end
  endtask

  task automatic test_rollback();
    int nb;
    idle();
    issue(3, 5);
    tick();
    issue(4, 6);
    tick();
    idle();
    bus.rollback = 1'b1;
    commit(3, 5, 32'h80);
    issue(4, 7);
    tick();
    idle();
    bus.rs1_id = 5'd3;
    bus.rs2_id = 5'd4;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'h80) begin
      failures++;
      $display("FAIL rb_x3 got=%0b/%h exp=0/80",
               bus.rs1_busy, bus.rs1_data);
    end
    checks++;
    if (bus.rs2_busy !== 1'b0 || bus.rs2_data !== 32'h0) begin
      failures++;
      $display("FAIL rb_x4 got=%0b/%h exp=0/0",
               bus.rs2_busy, bus.rs2_data);
    end
    nb = 0;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_id = i[4:0];
      #1;
      if (bus.rs1_busy !== 1'b0) nb++;
    end
    checks++;
    if (nb !== 0) begin
      failures++;
      $display("FAIL rb_allbusy got=%0d busy regs exp=0", nb);
    end
  endtask

  task automatic test_x0_rdy();
    idle();
    issue(0, 2);
    commit(0, 2, 32'hFF);
    tick();
    idle();
    bus.rs1_id = 5'd0;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0 || bus.rs1_data !== 32'h0) begin
      failures++;
      $display("FAIL x0 got=%0b/%h exp=0/0",
               bus.rs1_busy, bus.rs1_data);
    end
    bus.rdy = 1'b0;
    issue(8, 1);
    commit(3, 0, 32'h55);
    tick();
    idle();
    bus.rs1_id = 5'd8;
    bus.rs2_id = 5'd3;
    #1;
    checks++;
    if (bus.rs1_busy !== 1'b0) begin
      failures++;
      $display("FAIL rdy_x8 got=%0b exp=0", bus.rs1_busy);
    end
    checks++;
    if (bus.rs2_data !== 32'h80) begin
      failures++;
      $display("FAIL rdy_x3 got=%h exp=80", bus.rs2_data);
    end
  endtask

  task automatic test_random();
    int r, s1, s2;
    logic        eb1, eb2;
    logic [31:0] ed1, ed2;
    logic [3:0]  et1, et2;
    for (int n = 0; n < 600; n++) begin
      idle();
      bus.rdy      = ($urandom_range(0, 7) != 0);
      bus.rollback = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1)
        issue($urandom_range(0, 7), $urandom_range(0, ROB_SZ-1));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 7);
        commit(r,
               ($urandom_range(0, 3) == 0) ?
                 $urandom_range(0, ROB_SZ-1) : int'(m_tag[r]),
               $urandom);
      end
      s1 = ($urandom_range(0, 2) == 0) ?
             int'(bus.commit_rd) : $urandom_range(0, 7);
      s2 = $urandom_range(0, 31);
      bus.rs1_id = s1[4:0];
      bus.rs2_id = s2[4:0];
      #1;
      eb1 = m_busy[s1]; ed1 = m_reg[s1]; et1 = m_tag[s1];
      if (s1 != 0 && bus.commit_valid && m_busy[s1] &&
          int'(bus.commit_rd) == s1 &&
          m_tag[s1] == bus.commit_rob_id) begin
        eb1 = 0; ed1 = bus.commit_data;
      end
      eb2 = m_busy[s2]; ed2 = m_reg[s2]; et2 = m_tag[s2];
      if (s2 != 0 && bus.commit_valid && m_busy[s2] &&
          int'(bus.commit_rd) == s2 &&
          m_tag[s2] == bus.commit_rob_id) begin
        eb2 = 0; ed2 = bus.commit_data;
      end
      if (s1 == 0) begin eb1 = 0; ed1 = 0; end
      if (s2 == 0) begin eb2 = 0; ed2 = 0; end
      checks++;
      if (bus.rs1_busy !== eb1 ||
          (!eb1 && bus.rs1_data !== ed1) ||
          (eb1 && bus.rs1_rob_id !== et1)) begin
        failures++;
        $display("FAIL rnd_rs1 n=%0d x%0d got=%0b/%h/%0d exp=%0b/%h/%0d",
                 n, s1, bus.rs1_busy, bus.rs1_data, bus.rs1_rob_id,
                 eb1, ed1, et1);
      end
      checks++;
      if (bus.rs2_busy !== eb2 ||
          (!eb2 && bus.rs2_data !== ed2) ||
          (eb2 && bus.rs2_rob_id !== et2)) begin
        failures++;
        $display("FAIL rnd_rs2 n=%0d x%0d got=%0b/%h/%0d exp=%0b/%h/%0d",
                 n, s2, bus.rs2_busy, bus.rs2_data, bus.rs2_rob_id,
                 eb2, ed2, et2);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    bus.rs1_id = '0;
    bus.rs2_id = '0;
    test_reset();
    test_issue_commit();
    test_stale_commit();
    test_same_cycle();
    test_rollback();
    test_x0_rdy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
